// File: rtl/divekick_pkg.sv
// Shared Divekick definitions: fighter action encoding, screen geometry and
// the position clamp used by the motion controllers and the renderer.
package divekick_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int FIGHTER_W = 72;
    localparam int FIGHTER_H = 105;

    // Width of the signed position/velocity arithmetic.
    localparam int POS_W = 11;

    typedef enum logic [2:0] {
        GROUND = 3'd0,
        JUMP   = 3'd1,
        KICK   = 3'd2
    } fighter_state_e;

    typedef enum logic [1:0] {
        MV_GROUND,
        MV_JUMP,
        MV_HOP,
        MV_KICK
    } motion_e;

    function automatic logic [9:0] clamp_pos(input logic signed [POS_W-1:0] v,
                                             input logic [9:0] hi);
        if (v < 0)
            return '0;
        if (v > $signed({1'b0, hi}))
            return hi;
        return v[9:0];
    endfunction

endpackage

// File: rtl/fighter_motion_if.sv
// Button/renderer inputs and position/state outputs of one fighter.
interface fighter_motion_if;
    logic       frame_clk;
    logic       jump_key;
    logic       kick_key;
    logic       Freeze;
    logic       Restart;
    logic [9:0] X_Pos;
    logic [9:0] Y_Pos;
    logic [2:0] state;

    modport master (output frame_clk, jump_key, kick_key, Freeze, Restart,
                    input  X_Pos, Y_Pos, state);
    modport slave  (input  frame_clk, jump_key, kick_key, Freeze, Restart,
                    output X_Pos, Y_Pos, state);
endinterface

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous frame strobe into the Clk domain and emits a
// one-cycle tick on each rising edge of it.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);
    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = frame_clk;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign tick = s2_q & ~s3_q;
endmodule

// File: rtl/fighter_motion.sv
// Per-player fighter motion: turns jump/kick presses into position and action
// state once per frame. Define FIGHTER_LANDING_LAG_EN for dive-landing lockout.
module fighter_motion
    import divekick_pkg::*;
#(
    parameter int START_X      = 100,
    parameter int FACING_RIGHT = 1,
    parameter int GROUND_Y     = SCREEN_H - FIGHTER_H - 5,
    parameter int X_MAX        = SCREEN_W - FIGHTER_W - 1,
    parameter int JUMP_VEL     = 12,
    parameter int HOP_VEL      = 6,
    parameter int GRAVITY      = 1,
    parameter int DIVE_VX      = 6,
    parameter int DIVE_VY      = 6,
    parameter int HOP_VX       = 4,
    parameter int LAG_FRAMES   = 8
) (
    input logic             Clk,
    input logic             Reset,
    fighter_motion_if.slave bus
);
    localparam int DIR = (FACING_RIGHT != 0) ? 1 : -1;

    localparam logic signed [POS_W-1:0] JUMP_VY0   = POS_W'(-JUMP_VEL);
    localparam logic signed [POS_W-1:0] HOP_VY0    = POS_W'(-HOP_VEL);
    localparam logic signed [POS_W-1:0] HOP_VX0    = POS_W'(-HOP_VX * DIR);
    localparam logic signed [POS_W-1:0] DIVE_VX0   = POS_W'(DIVE_VX * DIR);
    localparam logic signed [POS_W-1:0] DIVE_VY0   = POS_W'(DIVE_VY);
    localparam logic signed [POS_W-1:0] GRAV       = POS_W'(GRAVITY);
    localparam logic signed [POS_W-1:0] GROUND_Y_S = POS_W'(GROUND_Y);
    localparam logic [9:0] START_X_P  = 10'(START_X);
    localparam logic [9:0] GROUND_Y_P = 10'(GROUND_Y);
    localparam logic [9:0] X_MAX_P    = 10'(X_MAX);

    logic                    tick;
    motion_e                 mv_q, mv_d;
    logic [9:0]              x_q, x_d, y_q, y_d;
    logic signed [POS_W-1:0] vx_q, vx_d, vy_q, vy_d;
    logic                    jp_q, jp_d, kp_q, kp_d;
    logic                    jk_q, jk_d, kk_q, kk_d;
    logic signed [POS_W-1:0] x_next, y_next;
    logic                    ground_ok;

`ifdef FIGHTER_LANDING_LAG_EN
    localparam logic [7:0] LAG_P = 8'(LAG_FRAMES);
    logic [7:0] lag_q, lag_d;
`else
    logic lag_unused;
    assign lag_unused = ^LAG_FRAMES;
`endif

    frame_tick_sync u_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (bus.frame_clk),
        .tick      (tick)
    );

    always_comb begin
        x_next = $signed({1'b0, x_q}) + vx_q;
        y_next = $signed({1'b0, y_q}) + vy_q;
        jk_d   = bus.jump_key;
        kk_d   = bus.kick_key;
        jp_d   = jp_q | (bus.jump_key & ~jk_q);
        kp_d   = kp_q | (bus.kick_key & ~kk_q);
        mv_d   = mv_q;
        x_d    = x_q;
        y_d    = y_q;
        vx_d   = vx_q;
        vy_d   = vy_q;
`ifdef FIGHTER_LANDING_LAG_EN
        lag_d     = lag_q;
        ground_ok = (lag_q == '0);
`else
        ground_ok = 1'b1;
`endif
        if (tick) begin
            // Presses live for one frame only, consumed or not.
            jp_d = 1'b0;
            kp_d = 1'b0;
            if (bus.Restart) begin
                mv_d = MV_GROUND;
                x_d  = START_X_P;
                y_d  = GROUND_Y_P;
                vx_d = '0;
                vy_d = '0;
`ifdef FIGHTER_LANDING_LAG_EN
                lag_d = '0;
`endif
            end else if (!bus.Freeze) begin
                case (mv_q)
                    MV_GROUND: begin
`ifdef FIGHTER_LANDING_LAG_EN
                        if (!ground_ok)
                            lag_d = lag_q - 8'd1;
`endif
                        if (ground_ok && jp_q) begin
                            mv_d = MV_JUMP;
                            vy_d = JUMP_VY0;
                        end else if (ground_ok && kp_q) begin
                            mv_d = MV_HOP;
                            vy_d = HOP_VY0;
                            vx_d = HOP_VX0;
                        end
                    end
                    default: begin
                        x_d = clamp_pos(x_next, X_MAX_P);
                        // Landing takes priority over any pending kick press.
                        if (y_next >= GROUND_Y_S) begin
                            mv_d = MV_GROUND;
                            y_d  = GROUND_Y_P;
                            vx_d = '0;
                            vy_d = '0;
`ifdef FIGHTER_LANDING_LAG_EN
                            if (mv_q == MV_KICK)
                                lag_d = LAG_P;
`endif
                        end else begin
                            y_d = clamp_pos(y_next, 10'h3ff);
                            if (mv_q != MV_KICK) begin
                                vy_d = vy_q + GRAV;
                                if (kp_q) begin
                                    mv_d = MV_KICK;
                                    vx_d = DIVE_VX0;
                                    vy_d = DIVE_VY0;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mv_q <= MV_GROUND;
            x_q  <= START_X_P;
            y_q  <= GROUND_Y_P;
            vx_q <= '0;
            vy_q <= '0;
            jp_q <= 1'b0;
            kp_q <= 1'b0;
            jk_q <= 1'b0;
            kk_q <= 1'b0;
        end else begin
            mv_q <= mv_d;
            x_q  <= x_d;
            y_q  <= y_d;
            vx_q <= vx_d;
            vy_q <= vy_d;
            jp_q <= jp_d;
            kp_q <= kp_d;
            jk_q <= jk_d;
            kk_q <= kk_d;
        end
    end

`ifdef FIGHTER_LANDING_LAG_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            lag_q <= '0;
        else
            lag_q <= lag_d;
    end
`endif

    assign bus.X_Pos = x_q;
    assign bus.Y_Pos = y_q;
    assign bus.state = (mv_q == MV_KICK)   ? KICK   :
                       (mv_q == MV_GROUND) ? GROUND : JUMP;
endmodule

// File: doc/fighter_motion.md
Name: fighter_motion

Overview:
Per-player motion and action controller for the Divekick game. Converts jump/kick button inputs into fighter position (top-left X/Y) and 3-bit action state once per video frame. Sits directly upstream of the frame renderer and drives its fighter_X_Pos/fighter_Y_Pos/p1_state (or player2_* / p2_state) inputs. It also consumes the renderer's Freeze and Restart outputs. Two instances are used, one per player.

Parameters:
START_X, 100, X_Pos after reset/Restart (0..X_MAX)
FACING_RIGHT, 1, 1 = forward is +X; 0 = forward is -X
GROUND_Y, 370, Y_Pos while standing (sprite 105 tall, bottom at 475)
X_MAX, 567, max X_Pos (640-72-1)
JUMP_VEL, 12, initial upward speed of jump (px/frame)
HOP_VEL, 6, initial upward speed of back-hop
GRAVITY, 1, vy increment per frame while airborne
DIVE_VX, 6, forward speed during dive-kick
DIVE_VY, 6, downward speed during dive-kick
HOP_VX, 4, backward speed during back-hop
LAG_FRAMES, 8, landing lockout length (optional feature only)

Ports:
Clk  in  1  50 MHz system clock
Reset  in  1  asynchronous, active-low reset
frame_clk  in  1  ~60 Hz frame strobe, asynchronous to Clk
jump_key  in  1  jump button level, active-high
kick_key  in  1  kick button level, active-high
Freeze  in  1  hold all motion (from renderer)
Restart  in  1  return to start condition (from renderer)
X_Pos  out  10  fighter top-left X
Y_Pos  out  10  fighter top-left Y
state  out  3  0=GROUND, 1=JUMP (also used for back-hop), 2=KICK

Behaviour:
- Reset (Reset=0, asynchronous): X_Pos=START_X, Y_Pos=GROUND_Y, state=0, vx=vy=0, key latches cleared, lag counter=0.
- Tick generation:
  - frame_clk passes through a 2-flop synchroniser, then an edge register.
  - tick = s2 & ~s3.
  - Outputs change on the Clk edge that samples tick=1, i.e. the 3rd Clk edge after frame_clk rises. At most one update per frame.
- Key latching:
  - A rising edge on jump_key or kick_key (sampled on Clk) sets jp/kp.
  - jp/kp are cleared on every tick, whether or not the press was consumed.
  - A held key does not retrigger.
- Internal FSM: GROUND, JUMP, HOP, KICK. HOP drives state=1.
  - GROUND:
    - jp wins over kp.
    - jp -> JUMP with vy=-JUMP_VEL.
    - kp alone -> HOP with vy=-HOP_VEL and vx=-HOP_VX*dir.
  - JUMP / HOP, each tick:
    - Y += vy, then vy += GRAVITY, then X += vx.
    - kp -> KICK with vx=+DIVE_VX*dir and vy=+DIVE_VY. The transition happens on this tick; dive motion applies from the next tick.
    - jp is ignored.
  - KICK: Y += DIVE_VY and X += vx each tick. Input is ignored.
  - Landing (any airborne state): if Y+vy >= GROUND_Y, then Y=GROUND_Y, vx=vy=0, state -> GROUND on the same tick.
- Arithmetic:
  - Positions and velocities use 11-bit signed internal arithmetic.
  - Y is clamped at 0 from below; vy is unaffected by the clamp.
  - X is clamped to [0, X_MAX]. Hitting a wall zeroes horizontal motion only for that tick; vx is retained.
- Freeze=1 at tick: no position, velocity or state change; latches still cleared.
- Restart=1 at tick: identical to the reset values (synchronous, tick-qualified). Restart wins over Freeze.
- Simultaneous press and landing on the same tick: the press is discarded; the fighter lands only.

Optional Feature:
FIGHTER_LANDING_LAG_EN
- Defined:
  - Landing from KICK loads a counter with LAG_FRAMES.
  - While the counter is nonzero, GROUND ignores jp/kp and the counter decrements once per non-frozen tick.
  - Restart clears the counter.
- Undefined: no counter; GROUND accepts input on the tick after landing.

Decomposition:
- divekick_pkg:
  - fighter_state_e (3-bit: GROUND=0, JUMP=1, KICK=2)
  - screen constants: SCREEN_W=640, SCREEN_H=480, FIGHTER_W=72, FIGHTER_H=105
  - shared by this block and the renderer.
- Sub-module frame_tick_sync: synchroniser + rising-edge pulse on Clk, async active-low Reset. Reusable by other per-frame blocks.

Test Plan:
- Jump from ground, defaults, single jump press:
  - Y at ticks 1/2/12 = 358/347/292, state=1.
  - Lands at tick 25 with Y=370, state=0, X unchanged at 100.
- Dive-kick: jump, kick press at tick 4 (Y=328), state=2 at tick 4.
  - Ticks 5..11: X +6/tick, Y +6/tick; Y=370 and state=0 at tick 11.
- Back-hop: kick press on ground, FACING_RIGHT=1, START_X=100:
  - state=1; X=96, 92, ... until landing at Y=370.
  - Jump+kick pressed same tick -> JUMP, not HOP.
- Wall clamp: START_X=565 with a forward dive -> X=567 and held there; Y still advances.
  - START_X=2 with a back-hop -> X=0.
- Freeze/Restart: Freeze mid-jump for 5 ticks -> outputs constant and the jump press during freeze is lost.
  - Freeze+Restart together -> X=100, Y=370, state=0 on that tick.
- Async reset mid-dive:
  - Reset low between Clk edges -> outputs = reset values immediately, independent of Clk.
  - Release -> no update until the next frame_clk edge.
  - FIGHTER_LANDING_LAG_EN build: a jump press at lag ticks 1..8 after dive landing is ignored; a jump press at tick 9 is accepted.
